ultrasonic_ranger: RTL

ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

---
 rtl/ultrasonic_ranger_pkg.sv | 23 ++
 rtl/us_tick_gen.sv | 29 ++
 rtl/ultrasonic_ranger.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ultrasonic_ranger_pkg.sv
// Shared state encoding and constants for the ultrasonic ranger.
package ultrasonic_ranger_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StHold
    } ranger_state_e;

    // Round-trip sound time per centimetre of range, in microseconds.
    localparam int unsigned UsPerCm = 58;

    // Saturation value; also reported when no complete echo was seen.
    localparam logic [9:0] DistSat = 10'd1023;

    // Saturating increment of the centimetre count.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == DistSat) ? DistSat : v + 10'd1;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every microsecond.
module us_tick_gen #(
    parameter int unsigned CLK_PER_US = 50
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);

    localparam int unsigned CntW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_PER_US - 1);

    logic [CntW-1:0] cnt_q;

    // With one clock per microsecond the counter sits at 0 and tick stays high.
    assign tick = (cnt_q == CntMax);

    // Count 0..CLK_PER_US-1 and wrap.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic range finder controller: triggers the sensor periodically and
// converts the echo pulse width into a saturating distance in centimetres.
module ultrasonic_ranger
    import ultrasonic_ranger_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned PERIOD_MS  = 60,
    parameter int unsigned TIMEOUT_US = 25000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       enable,
    input  logic       echo,
    output logic       trig,
    output logic [9:0] distancia,
    output logic       valid,
    output logic       timeout
);

    localparam int unsigned PeriodTicks = PERIOD_MS * 1000;
    localparam logic [31:0] TrigLast    = 32'(TRIG_US - 1);
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_US - 1);
    localparam logic [31:0] PeriodLast  = 32'(PeriodTicks - 1);
    localparam logic [5:0]  SubLast     = 6'(UsPerCm - 1);

    logic          tick;
    logic          echo_meta_q, echo_sync_q, echo_prev_q;
    logic          echo_rise, echo_fall;
    ranger_state_e state_q, state_d;
    logic [31:0]   period_q, period_d;
    logic [31:0]   phase_q, phase_d;
    logic [5:0]    sub_q, sub_d, sub_step;
    logic [9:0]    cm_q, cm_d, cm_step;
    logic [9:0]    dist_q, dist_d;
    logic          timeout_q, timeout_d;
    logic          valid_q, valid_d;

    us_tick_gen #(
        .CLK_PER_US (CLK_HZ / 1_000_000)
    ) u_us_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick)
    );

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_sync_q <= echo_meta_q;
            echo_prev_q <= echo_sync_q;
        end
    end

    assign echo_rise = echo_sync_q & ~echo_prev_q;
    assign echo_fall = ~echo_sync_q & echo_prev_q;

    // One microsecond of echo: advance the 0..57 sub-counter, carry into centimetres.
    assign sub_step = (sub_q == SubLast) ? 6'd0 : sub_q + 6'd1;
    assign cm_step  = (sub_q == SubLast) ? sat_inc(cm_q) : cm_q;

    // State, counters and result registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            period_q  <= '0;
            phase_q   <= '0;
            sub_q     <= '0;
            cm_q      <= '0;
            dist_q    <= DistSat;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            phase_q   <= phase_d;
            sub_q     <= sub_d;
            cm_q      <= cm_d;
            dist_q    <= dist_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state logic; phase_q times the current state, period_q the whole cycle.
    always_comb begin
        state_d   = state_q;
        period_d  = (tick && state_q != StIdle) ? period_q + 32'd1 : period_q;
        phase_d   = phase_q;
        sub_d     = sub_q;
        cm_d      = cm_q;
        dist_d    = dist_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d  = StTrig;
                    period_d = '0;
                    phase_d  = '0;
                end
            end
            StTrig: begin
                if (tick) begin
                    if (phase_q == TrigLast) begin
                        state_d = StWaitRise;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 32'd1;
                    end
                end
            end
            StWaitRise: begin
                if (echo_rise) begin
                    state_d = StMeasure;
                    phase_d = '0;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (tick) begin
                    if (phase_q == TimeoutLast) begin
                        state_d   = StHold;
                        dist_d    = DistSat;
                        timeout_d = 1'b1;
                        valid_d   = 1'b1;
                    end else begin
                        phase_d = phase_q + 32'd1;
                    end
                end
            end
            StMeasure: begin
                // The falling-edge cycle still counts as a microsecond of echo.
                if (echo_fall) begin
                    state_d   = StHold;
                    dist_d    = tick ? cm_step : cm_q;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                end else if (tick) begin
                    if (phase_q == TimeoutLast) begin
                        state_d   = StHold;
                        dist_d    = DistSat;
                        timeout_d = 1'b1;
                        valid_d   = 1'b1;
                    end else begin
                        phase_d = phase_q + 32'd1;
                        sub_d   = sub_step;
                        cm_d    = cm_step;
                    end
                end
            end
            StHold: begin
                if (tick && period_q >= PeriodLast) begin
                    if (enable) begin
                        state_d  = StTrig;
                        period_d = '0;
                        phase_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign trig      = (state_q == StTrig);
    assign distancia = dist_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;

endmodule
